decode_pipe: RTL

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pkg.sv | 88 ++++++++
 rtl/decode_pipe_regbank.sv | 68 ++++++
 rtl/decode_pipe.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared types and constants for the decode stage.
//   ctrl_t     - packed control bundle carried down the pipeline
//   OP_*       - supported primary opcodes (instruction bits 31:26)
//   IMM_*      - ALU function codes for immediate-form ALU ops, placed in ctrl_t.other
//   decode_op  - opcode -> control bundle
//   op_reads_rt- whether an opcode sources its rt field as a register operand
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    // aluop=2'b11 marks an immediate ALU op; 'other' then selects the function.
    localparam logic [3:0] IMM_ADD = 4'h0;
    localparam logic [3:0] IMM_AND = 4'h1;
    localparam logic [3:0] IMM_OR  = 4'h2;

    typedef struct packed {
        logic       regdst;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
        logic [3:0] other;
        logic       zext;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t decode_op(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
                c.aluop    = 2'b10;
            end
            OP_LW: begin
                c.memread  = 1'b1;
                c.memtoreg = 1'b1;
                c.alusrc   = 1'b1;
                c.regwrite = 1'b1;
            end
            OP_SW: begin
                c.memwrite = 1'b1;
                c.alusrc   = 1'b1;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.aluop  = 2'b01;
            end
            OP_ADDI: begin
                c.alusrc   = 1'b1;
                c.regwrite = 1'b1;
                c.aluop    = 2'b11;
                c.other    = IMM_ADD;
            end
            OP_ANDI: begin
                c.alusrc   = 1'b1;
                c.regwrite = 1'b1;
                c.aluop    = 2'b11;
                c.other    = IMM_AND;
                c.zext     = 1'b1;
            end
            OP_ORI: begin
                c.alusrc   = 1'b1;
                c.regwrite = 1'b1;
                c.aluop    = 2'b11;
                c.other    = IMM_OR;
                c.zext     = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    function automatic logic op_reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/decode_pipe_regbank.sv
// register_bank_p: NREG x DATA_W register file.
//   i_clk, i_rst         - clock, synchronous active-high reset (clears every entry)
//   i_we/i_waddr/i_wdata - synchronous write port
//   i_raddr_a/o_rdata_a  - asynchronous read port A
//   i_raddr_b/o_rdata_b  - asynchronous read port B
// Entry 0 and any address >= NREG read as zero and are never written.
// With BYPASS_EN!=0 a read of the address being written returns the write data.
module register_bank_p #(
    parameter int DATA_W    = 32,
    parameter int NREG      = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [4:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [4:0]        i_raddr_a,
    input  logic [4:0]        i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    localparam int         REG_AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [5:0] NREG_L = 6'(NREG);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   wr_sel;
    logic              wr_en;
    logic [4:0]        raddr [2];

    assign wr_en    = i_we && (i_waddr != 5'd0) && ({1'b0, i_waddr} < NREG_L);
    assign raddr[0] = i_raddr_a;
    assign raddr[1] = i_raddr_b;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_wsel
            assign wr_sel[gi] = wr_en && (i_waddr == 5'(gi));
        end

        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] data;
            always_comb begin
                data = '0;
                if ((raddr[gi] != 5'd0) && ({1'b0, raddr[gi]} < NREG_L)) begin
                    if ((BYPASS_EN != 0) && wr_en && (i_waddr == raddr[gi]))
                        data = i_wdata;
                    else
                        data = regs_q[raddr[gi][REG_AW-1:0]];
                end
            end
        end
    endgenerate

    assign o_rdata_a = g_rd[0].data;
    assign o_rdata_b = g_rd[1].data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (wr_sel[i]) regs_q[i] <= i_wdata;
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: instruction decode stage with register read, load-use hazard
// detection and the decode/execute pipeline register.
//   i_clk, i_rst                 - clock, synchronous active-high reset
//   i_valid, i_data_Instr        - fetched instruction and its valid
//   i_addr_NextPC                - PC+4 of that instruction, passed through
//   i_hold                       - downstream stall: freeze the output register
//   i_flush                      - branch taken: kill the instruction in decode
//   i_ex_memread, i_ex_rt        - load currently in EX and its destination
//   i_con_RegWr/i_addr_WrReg/i_data_WrData - writeback port (never blocked)
//   o_stall                      - freeze fetch (hazard or hold, unless flushing)
//   o_valid, o_ctrl, o_data_*, o_addr_* - registered stage outputs
module decode_pipe
    import decode_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NREG      = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [31:0]       i_data_Instr,
    input  logic [31:0]       i_addr_NextPC,
    input  logic              i_hold,
    input  logic              i_flush,
    input  logic              i_ex_memread,
    input  logic [4:0]        i_ex_rt,
    input  logic              i_con_RegWr,
    input  logic [4:0]        i_addr_WrReg,
    input  logic [DATA_W-1:0] i_data_WrData,
    output logic              o_stall,
    output logic              o_valid,
    output ctrl_t             o_ctrl,
    output logic [31:0]       o_addr_NextPC,
    output logic [DATA_W-1:0] o_data_rs,
    output logic [DATA_W-1:0] o_data_rt,
    output logic [DATA_W-1:0] o_data_Imm,
    output logic [4:0]        o_addr_rs,
    output logic [4:0]        o_addr_rt,
    output logic [4:0]        o_addr_rd
);

    logic [5:0]        opcode;
    logic [4:0]        rs_addr, rt_addr, rd_addr;
    logic [15:0]       imm16;
    ctrl_t             ctrl_dec;
    logic [DATA_W-1:0] imm_ext, rs_data, rt_data;
    logic              hazard;

    assign opcode  = i_data_Instr[31:26];
    assign rs_addr = i_data_Instr[25:21];
    assign rt_addr = i_data_Instr[20:16];
    assign rd_addr = i_data_Instr[15:11];
    assign imm16   = i_data_Instr[15:0];

    assign ctrl_dec = decode_op(opcode);
    assign imm_ext  = ctrl_dec.zext ? {{(DATA_W-16){1'b0}}, imm16}
                                    : {{(DATA_W-16){imm16[15]}}, imm16};

    // Load-use: the load in EX cannot forward in time, so hold fetch one cycle.
    assign hazard = i_valid && i_ex_memread && (i_ex_rt != 5'd0) &&
                    ((i_ex_rt == rs_addr) || ((i_ex_rt == rt_addr) && op_reads_rt(opcode)));

    assign o_stall = (hazard || i_hold) && !i_flush && !i_rst;

    register_bank_p #(
        .DATA_W    (DATA_W),
        .NREG      (NREG),
        .BYPASS_EN (BYPASS_EN)
    ) u_regbank (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (i_con_RegWr),
        .i_waddr   (i_addr_WrReg),
        .i_wdata   (i_data_WrData),
        .i_raddr_a (rs_addr),
        .i_raddr_b (rt_addr),
        .o_rdata_a (rs_data),
        .o_rdata_b (rt_data)
    );

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [31:0]       next_pc_q, next_pc_d;
    logic [DATA_W-1:0] data_rs_q, data_rs_d, data_rt_q, data_rt_d, imm_q, imm_d;
    logic [4:0]        addr_rs_q, addr_rs_d, addr_rt_q, addr_rt_d, addr_rd_q, addr_rd_d;

    // Priority: flush > hold > bubble (hazard / no input) > capture.
    // Bubbles clear only valid and ctrl; the data fields are don't-care.
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        next_pc_d = next_pc_q;
        data_rs_d = data_rs_q;
        data_rt_d = data_rt_q;
        imm_d     = imm_q;
        addr_rs_d = addr_rs_q;
        addr_rt_d = addr_rt_q;
        addr_rd_d = addr_rd_q;
        if (i_flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (i_hold) begin
            valid_d = valid_q;
        end else if (hazard || !i_valid) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else begin
            valid_d   = 1'b1;
            ctrl_d    = ctrl_dec;
            next_pc_d = i_addr_NextPC;
            data_rs_d = rs_data;
            data_rt_d = rt_data;
            imm_d     = imm_ext;
            addr_rs_d = rs_addr;
            addr_rt_d = rt_addr;
            addr_rd_d = rd_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            next_pc_q <= '0;
            data_rs_q <= '0;
            data_rt_q <= '0;
            imm_q     <= '0;
            addr_rs_q <= '0;
            addr_rt_q <= '0;
            addr_rd_q <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            next_pc_q <= next_pc_d;
            data_rs_q <= data_rs_d;
            data_rt_q <= data_rt_d;
            imm_q     <= imm_d;
            addr_rs_q <= addr_rs_d;
            addr_rt_q <= addr_rt_d;
            addr_rd_q <= addr_rd_d;
        end
    end

    assign o_valid       = valid_q;
    assign o_ctrl        = ctrl_q;
    assign o_addr_NextPC = next_pc_q;
    assign o_data_rs     = data_rs_q;
    assign o_data_rt     = data_rt_q;
    assign o_data_Imm    = imm_q;
    assign o_addr_rs     = addr_rs_q;
    assign o_addr_rt     = addr_rt_q;
    assign o_addr_rd     = addr_rd_q;

endmodule
